// File: rtl/ir_ctrl_pkg.sv
// Shared encodings for the NEC IR drive controller: motion codes, key codes, FSM states.
package ir_ctrl_pkg;

  localparam int unsigned MOT_W = 3;
  localparam int unsigned SPD_W = 3;
  localparam int unsigned ERR_W = 8;

  localparam logic [MOT_W-1:0] MOT_STOP  = 3'd0;
  localparam logic [MOT_W-1:0] MOT_FWD   = 3'd1;
  localparam logic [MOT_W-1:0] MOT_BACK  = 3'd2;
  localparam logic [MOT_W-1:0] MOT_LEFT  = 3'd3;
  localparam logic [MOT_W-1:0] MOT_RIGHT = 3'd4;

  localparam logic [7:0] KEY_FWD    = 8'h18;
  localparam logic [7:0] KEY_BACK   = 8'h52;
  localparam logic [7:0] KEY_LEFT   = 8'h08;
  localparam logic [7:0] KEY_RIGHT  = 8'h5A;
  localparam logic [7:0] KEY_STOP   = 8'h1C;
  localparam logic [7:0] KEY_SPD_UP = 8'h15;
  localparam logic [7:0] KEY_SPD_DN = 8'h07;

  typedef enum logic {
    ST_IDLE,
    ST_DRIVE
  } state_e;

  // Motion keys only; STOP and speed keys are handled separately.
  function automatic logic is_motion_key(input logic [7:0] cmd);
    return (cmd == KEY_FWD) || (cmd == KEY_BACK) ||
           (cmd == KEY_LEFT) || (cmd == KEY_RIGHT);
  endfunction

  function automatic logic [MOT_W-1:0] key_to_motion(input logic [7:0] cmd);
    logic [MOT_W-1:0] m;
    case (cmd)
      KEY_FWD:   m = MOT_FWD;
      KEY_BACK:  m = MOT_BACK;
      KEY_LEFT:  m = MOT_LEFT;
      KEY_RIGHT: m = MOT_RIGHT;
      default:   m = MOT_STOP;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ir_hold_timer.sv
// Motion hold countdown: load has priority over clear, clear over decrement.
module ir_hold_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clr,
  input  logic             dec_en,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire_c
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (clr) begin
      cnt <= '0;
    end else if (dec_en && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  // Last cycle of the hold window; the caller decides whether a reload overrides it.
  assign expire_c = dec_en && (cnt == WIDTH'(1));

endmodule

// File: rtl/ir_drive_ctrl.sv
// NEC IR command scheduler: validates frames, maps keys to motion/speed, holds on repeats.
// Optional build macro IR_ADDR_FILTER_EN adds address byte checking against MY_ADDR.
module ir_drive_ctrl
  import ir_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned HOLD_MS    = 120,
  parameter int unsigned SPEED_INIT = 3,
  parameter logic [7:0]  MY_ADDR    = 8'h00
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        frame_vld,
  input  logic [31:0] frame_data,
  input  logic        rpt_vld,
  output logic [2:0]  motion,
  output logic [2:0]  speed,
  output logic        cmd_vld,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int unsigned HOLD_CYC = CLK_HZ / 1000 * HOLD_MS;
  localparam int unsigned TMR_W    = $clog2(HOLD_CYC + 1);

  state_e            state, state_d;
  logic [MOT_W-1:0]  motion_d;
  logic [SPD_W-1:0]  speed_d;
  logic [ERR_W-1:0]  err_d;
  logic              cmd_vld_d;
  logic              tmr_load, tmr_clr, tmr_expire_c;
  logic [7:0]        cmd, cmd_n;
  logic              frame_ok, accept, reject;

  assign cmd   = frame_data[15:8];
  assign cmd_n = frame_data[7:0];

`ifdef IR_ADDR_FILTER_EN
  assign frame_ok = ((cmd ^ cmd_n) == 8'hFF) &&
                    (frame_data[31:24] == MY_ADDR) &&
                    ((frame_data[31:24] ^ frame_data[23:16]) == 8'hFF);
`else
  logic unused_addr;
  assign unused_addr = ^{frame_data[31:16], MY_ADDR};
  assign frame_ok    = ((cmd ^ cmd_n) == 8'hFF);
`endif

  assign accept = frame_vld && frame_ok;
  assign reject = frame_vld && !frame_ok;

  ir_hold_timer #(.WIDTH(TMR_W)) u_hold_timer (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .clr      (tmr_clr),
    .dec_en   (state == ST_DRIVE),
    .load_val (TMR_W'(HOLD_CYC)),
    .expire_c (tmr_expire_c)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d   = state;
    motion_d  = motion;
    speed_d   = speed;
    err_d     = err_cnt;
    cmd_vld_d = 1'b0;
    tmr_load  = 1'b0;
    tmr_clr   = 1'b0;

    if (reject && (err_cnt != 8'hFF)) err_d = err_cnt + 8'd1;

    if (accept && (cmd == KEY_SPD_UP)) begin
      cmd_vld_d = 1'b1;
      if (speed != 3'd7) speed_d = speed + 3'd1;
    end else if (accept && (cmd == KEY_SPD_DN)) begin
      cmd_vld_d = 1'b1;
      if (speed != 3'd0) speed_d = speed - 3'd1;
    end

    case (state)
      ST_IDLE: begin
        if (accept && is_motion_key(cmd)) begin
          state_d   = ST_DRIVE;
          motion_d  = key_to_motion(cmd);
          tmr_load  = 1'b1;
          cmd_vld_d = 1'b1;
        end else if (accept && (cmd == KEY_STOP)) begin
          motion_d  = MOT_STOP;
          cmd_vld_d = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (accept && is_motion_key(cmd)) begin
          motion_d  = key_to_motion(cmd);
          tmr_load  = 1'b1;
          cmd_vld_d = 1'b1;
        end else if (accept && (cmd == KEY_STOP)) begin
          state_d   = ST_IDLE;
          motion_d  = MOT_STOP;
          tmr_clr   = 1'b1;
          cmd_vld_d = 1'b1;
        end else if (rpt_vld && !frame_vld) begin
          tmr_load = 1'b1;
        end else if (tmr_expire_c) begin
          state_d  = ST_IDLE;
          motion_d = MOT_STOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      motion  <= MOT_STOP;
      speed   <= SPD_W'(SPEED_INIT);
      cmd_vld <= 1'b0;
      busy    <= 1'b0;
      err_cnt <= '0;
    end else begin
      motion  <= motion_d;
      speed   <= speed_d;
      cmd_vld <= cmd_vld_d;
      busy    <= (state_d == ST_DRIVE);
      err_cnt <= err_d;
    end
  end

endmodule

// File: tb/tb_ir_drive_ctrl.sv
// Directed bench for ir_drive_ctrl with CLK_HZ=1000, HOLD_MS=10 (10-cycle hold).
module tb_ir_drive_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        frame_vld;
  logic [31:0] frame_data;
  logic        rpt_vld;
  logic [2:0]  motion;
  logic [2:0]  speed;
  logic        cmd_vld;
  logic        busy;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] F_FWD   = 32'h00FF18E7;
  localparam logic [31:0] F_BACK  = 32'h00FF52AD;
  localparam logic [31:0] F_LEFT  = 32'h00FF08F7;
  localparam logic [31:0] F_RIGHT = 32'h00FF5AA5;
  localparam logic [31:0] F_STOP  = 32'h00FF1CE3;
  localparam logic [31:0] F_UP    = 32'h00FF15EA;
  localparam logic [31:0] F_DN    = 32'h00FF07F8;
  localparam logic [31:0] F_BAD   = 32'h00FF1800;
  localparam logic [31:0] F_UNMAP = 32'h00FF45BA;

  ir_drive_ctrl #(
    .CLK_HZ     (1000),
    .HOLD_MS    (10),
    .SPEED_INIT (3),
    .MY_ADDR    (8'h00)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .frame_vld  (frame_vld),
    .frame_data (frame_data),
    .rpt_vld    (rpt_vld),
    .motion     (motion),
    .speed      (speed),
    .cmd_vld    (cmd_vld),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    frame_vld  = 1'b1;
    frame_data = d;
    tick();
    frame_vld  = 1'b0;
  endtask

  task automatic repeat_code();
    rpt_vld = 1'b1;
    tick();
    rpt_vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; frame_vld = 1'b0; frame_data = '0; rpt_vld = 1'b0;
    tick(); tick();
    check("rst_motion", 32'(motion), 32'd0);
    check("rst_speed", 32'(speed), 32'd3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_cmd_vld", 32'(cmd_vld), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single FWD frame, hold for exactly 10 cycles
    send(F_FWD);
    check("t1_motion", 32'(motion), 32'd1);
    check("t1_cmd_vld", 32'(cmd_vld), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_cmd_vld_pulse", 32'(cmd_vld), 32'd0);
    repeat (8) tick();
    check("t1_hold_last", 32'(motion), 32'd1);
    tick();
    check("t1_expired", 32'(motion), 32'd0);
    check("t1_busy_off", 32'(busy), 32'd0);

    // 2: repeats every 8 cycles extend the hold
    send(F_FWD);
    for (int i = 0; i < 3; i++) begin
      repeat (7) tick();
      repeat_code();
      check("t2_rpt_motion", 32'(motion), 32'd1);
      check("t2_rpt_no_cmd_vld", 32'(cmd_vld), 32'd0);
    end
    repeat (9) tick();
    check("t2_hold_last", 32'(motion), 32'd1);
    tick();
    check("t2_expired", 32'(motion), 32'd0);

    // 3: bad frames counted, unmapped valid keys ignored, counter saturates
    send(F_FWD);
    send(F_BAD);
    check("t3_err1", 32'(err_cnt), 32'd1);
    check("t3_motion_kept", 32'(motion), 32'd1);
    check("t3_no_cmd_vld", 32'(cmd_vld), 32'd0);
    send(F_UNMAP);
    check("t3_unmap_err", 32'(err_cnt), 32'd1);
    check("t3_unmap_cmd_vld", 32'(cmd_vld), 32'd0);
    check("t3_unmap_motion", 32'(motion), 32'd1);
    for (int i = 0; i < 253; i++) send(F_BAD);
    check("t3_err254", 32'(err_cnt), 32'hFE);
    for (int i = 0; i < 46; i++) send(F_BAD);
    check("t3_err_sat", 32'(err_cnt), 32'hFF);
    check("t3_idle_after", 32'(motion), 32'd0);

    // 4: speed saturation, no state change
    send(F_UP); send(F_UP);
    check("t4_spd5", 32'(speed), 32'd5);
    check("t4_spd_cmd_vld", 32'(cmd_vld), 32'd1);
    for (int i = 0; i < 4; i++) send(F_UP);
    check("t4_spd7", 32'(speed), 32'd7);
    check("t4_up_busy", 32'(busy), 32'd0);
    send(F_FWD);
    for (int i = 0; i < 3; i++) send(F_DN);
    check("t4_spd4", 32'(speed), 32'd4);
    for (int i = 0; i < 6; i++) send(F_DN);
    check("t4_spd0", 32'(speed), 32'd0);
    check("t4_dn_busy", 32'(busy), 32'd1);
    check("t4_dn_motion", 32'(motion), 32'd1);
    tick();
    check("t4_no_reload", 32'(motion), 32'd0);

    // 5: STOP with simultaneous repeat; repeat must not keep DRIVE alive
    send(F_FWD);
    rpt_vld = 1'b1;
    send(F_STOP);
    rpt_vld = 1'b0;
    check("t5_motion", 32'(motion), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_cmd_vld", 32'(cmd_vld), 32'd1);
    repeat (3) tick();
    check("t5_stay_idle", 32'(busy), 32'd0);
    send(F_STOP);
    check("t5_idle_stop_cmd_vld", 32'(cmd_vld), 32'd1);
    check("t5_idle_stop_busy", 32'(busy), 32'd0);

    // 6: back-to-back motion keys, then reset mid-DRIVE
    send(F_FWD);   check("t6_fwd", 32'(motion), 32'd1);
    send(F_BACK);  check("t6_back", 32'(motion), 32'd2);
    send(F_LEFT);  check("t6_left", 32'(motion), 32'd3);
    send(F_RIGHT); check("t6_right", 32'(motion), 32'd4);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_rst_motion", 32'(motion), 32'd0);
    check("t6_rst_speed", 32'(speed), 32'd3);
    check("t6_rst_err", 32'(err_cnt), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    tick();

    send(32'h01FE18E7);
`ifdef IR_ADDR_FILTER_EN
    check("t6_addr_err", 32'(err_cnt), 32'd1);
    check("t6_addr_motion", 32'(motion), 32'd0);
`else
    check("t6_addr_ignored_err", 32'(err_cnt), 32'd0);
    check("t6_addr_ignored_motion", 32'(motion), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
